act_writeback: RTL and testbench

ACT_WRITEBACK -- requirements
Module: act_writeback

---
 rtl/act_writeback.sv | 139 +++++++++++++
 tb/tb_act_writeback.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/act_writeback.sv
`default_nettype none
// ============================================================================
// Module   : act_writeback
// Purpose  : Bias-add, ReLU, shift and saturate neuron sums into a
//            double-buffered 8-bit activation store with per-entry written mask.
// Revision : 1.0 - initial release
// ============================================================================
module act_writeback #(
  parameter int DATA_W = 16,
  parameter int SHIFT  = 4,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_valid,
  output logic              acc_ready,
  input  logic [DATA_W-1:0] acc_data,
  input  logic [AW-1:0]     acc_addr,
  input  logic [DATA_W-1:0] bias_data,
  input  logic              layer_done,
  input  logic [AW-1:0]     rd_addr,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              wr_bank,
  output logic [4:0]        layer_cnt,
  output logic              busy
);

  localparam logic [4:0] c_MAX_LAYERS = 5'd20;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_SWAP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_s1_vld;
  logic [DATA_W:0]   r_y;
  logic [AW-1:0]     r_a1;
  logic              r_s2_vld;
  logic [7:0]        r_res;
  logic [AW-1:0]     r_a2;
  logic              r_wr_bank;
  logic [4:0]        r_layer_cnt;
  logic [DEPTH-1:0]  r_mask [2];
  logic [7:0]        r_mem  [2][DEPTH];
  logic [7:0]        r_rd_data;
  logic              r_rd_valid;

  logic              w_xfer;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_q;
  logic [7:0]        w_res;
  logic [4:0]        w_cnt_nxt;

  // Ready is forced low while reset is held, even though the state is IDLE.
  assign acc_ready = rst & ((r_state == S_IDLE) | (r_state == S_RUN));
  assign w_xfer    = acc_valid & acc_ready;

  // One guard bit makes the bias add exact for any pair of inputs.
  assign w_sum = {acc_data[DATA_W-1], acc_data} + {bias_data[DATA_W-1], bias_data};
  assign w_q   = r_y >> SHIFT;
  assign w_res = r_y[DATA_W]    ? 8'd0  :
                 (|w_q[DATA_W:8]) ? 8'hFF : w_q[7:0];

  assign w_cnt_nxt = (r_layer_cnt == c_MAX_LAYERS) ? c_MAX_LAYERS : r_layer_cnt + 5'd1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (acc_valid)              w_state_nxt = S_RUN;
      S_RUN:   if (layer_done)             w_state_nxt = S_DRAIN;
      S_DRAIN: if (!r_s1_vld && !r_s2_vld) w_state_nxt = S_SWAP;
      S_SWAP:  w_state_nxt = (w_cnt_nxt < c_MAX_LAYERS) ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_s1_vld    <= 1'b0;
      r_y         <= '0;
      r_a1        <= '0;
      r_s2_vld    <= 1'b0;
      r_res       <= '0;
      r_a2        <= '0;
      r_wr_bank   <= 1'b0;
      r_layer_cnt <= '0;
      r_mask[0]   <= '0;
      r_mask[1]   <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_s1_vld <= w_xfer;
      if (w_xfer) begin
        r_y  <= w_sum;
        r_a1 <= acc_addr;
      end
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_res <= w_res;
        r_a2  <= r_a1;
      end
      if (r_s2_vld) begin
        r_mask[r_wr_bank][r_a2] <= 1'b1;
      end
      // Pipeline is empty in SWAP, so the mask clear never races a write.
      if (r_state == S_SWAP) begin
        r_wr_bank          <= ~r_wr_bank;
        r_mask[~r_wr_bank] <= '0;
        r_layer_cnt        <= w_cnt_nxt;
      end
      r_rd_data  <= r_mem[~r_wr_bank][rd_addr];
      r_rd_valid <= r_mask[~r_wr_bank][rd_addr];
    end
  end

  // Activation storage is not reset; the masks qualify every read.
  always_ff @(posedge clk) begin
    if (r_s2_vld) begin
      r_mem[r_wr_bank][r_a2] <= r_res;
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign wr_bank   = r_wr_bank;
  assign layer_cnt = r_layer_cnt;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_act_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_act_writeback
// Purpose  : Directed, table-driven self-checking bench for act_writeback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_act_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        acc_valid = 1'b0;
  logic        acc_ready;
  logic [15:0] acc_data = '0;
  logic [3:0]  acc_addr = '0;
  logic [15:0] bias_data = '0;
  logic        layer_done = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        wr_bank;
  logic [4:0]  layer_cnt;
  logic        busy;

  act_writeback #(.DATA_W(16), .SHIFT(4), .DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_data(acc_data), .acc_addr(acc_addr), .bias_data(bias_data),
    .layer_done(layer_done),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_bank(wr_bank), .layer_cnt(layer_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int bias;
    int addr;
    int exp;
  } vec_t;

  vec_t vt[11];
  int   exp_v[16];
  int   exp_d[16];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int d, input int b, input int a, input bit done);
    chk("ready_at_xfer", int'(acc_ready), 1);
    acc_valid  = 1'b1;
    acc_data   = d[15:0];
    bias_data  = b[15:0];
    acc_addr   = a[3:0];
    layer_done = done;
    tick;
    acc_valid  = 1'b0;
    layer_done = 1'b0;
  endtask

  // Counts cycles with acc_ready low; optionally keeps offering a bogus
  // transfer (addr 5) that must never be accepted.
  task automatic wait_ready(input string nm, input int exp_low, input bit hold);
    int n;
    n = 0;
    acc_valid = hold;
    acc_addr  = 4'd5;
    acc_data  = 16'd160;
    bias_data = 16'd0;
    while (!acc_ready && n < 20) begin
      tick;
      n++;
    end
    acc_valid = 1'b0;
    chk(nm, n, exp_low);
  endtask

  task automatic pulse_done(input string nm, input int exp_low, input bit hold);
    layer_done = 1'b1;
    tick;
    layer_done = 1'b0;
    wait_ready(nm, exp_low, hold);
  endtask

  task automatic read_all(input string nm);
    for (int a = 0; a < 16; a++) begin
      rd_addr = a[3:0];
      tick;
      chk({nm, "_valid"}, int'(rd_valid), exp_v[a]);
      if (exp_v[a] != 0) chk({nm, "_data"}, int'(rd_data), exp_d[a]);
    end
  endtask

  task automatic clear_model;
    for (int a = 0; a < 16; a++) begin
      exp_v[a] = 0;
      exp_d[a] = 0;
    end
  endtask

  initial begin
    vt[0]  = '{100,    60,     3, 10};
    vt[1]  = '{-50,    20,     5, 0};
    vt[2]  = '{32767,  32767,  6, 255};
    vt[3]  = '{-32768, -32768, 7, 0};
    vt[4]  = '{4095,   0,      8, 255};
    vt[5]  = '{4096,   0,      9, 255};
    vt[6]  = '{15,     0,      10, 0};
    vt[7]  = '{16,     0,      11, 1};
    vt[8]  = '{-1,     1,      12, 0};
    vt[9]  = '{200,    -40,    13, 10};
    vt[10] = '{50,     0,      3, 3};

    // Reset state
    repeat (3) tick;
    chk("rst_ready", int'(acc_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_bank", int'(wr_bank), 0);
    chk("rst_layer_cnt", int'(layer_cnt), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    rst = 1'b1;
    #1;
    chk("post_rst_ready", int'(acc_ready), 1);

    // Round 1: table vectors back to back, last one coincides with layer_done
    clear_model;
    for (int i = 0; i < 11; i++) begin
      xfer(vt[i].data, vt[i].bias, vt[i].addr, (i == 10));
      exp_v[vt[i].addr] = 1;
      exp_d[vt[i].addr] = vt[i].exp;
      if (i == 0) chk("busy_after_first", int'(busy), 1);
    end
    wait_ready("r1_drain_swap_cycles", 4, 1'b0);
    chk("r1_wr_bank", int'(wr_bank), 1);
    chk("r1_layer_cnt", int'(layer_cnt), 1);
    read_all("r1");

    // Round 2: full bank back to back, layer_done on its own cycle
    clear_model;
    for (int i = 0; i < 16; i++) begin
      xfer(i * 32, 0, i, 1'b0);
      exp_v[i] = 1;
      exp_d[i] = 2 * i;
    end
    pulse_done("r2_drain_swap_cycles", 3, 1'b0);
    chk("r2_wr_bank", int'(wr_bank), 0);
    chk("r2_layer_cnt", int'(layer_cnt), 2);
    read_all("r2");

    // Round 3: reused bank must have a cleared mask; held acc_valid in DRAIN ignored
    clear_model;
    xfer(48, 0, 0, 1'b0);
    exp_v[0] = 1;
    exp_d[0] = 3;
    pulse_done("r3_drain_swap_cycles", 3, 1'b1);
    chk("r3_wr_bank", int'(wr_bank), 1);
    read_all("r3");

    // Rounds 4..20 with no data, then saturation
    for (int r = 4; r <= 20; r++) begin
      pulse_done("empty_round_cycles", 2, 1'b0);
    end
    chk("r20_layer_cnt", int'(layer_cnt), 20);
    chk("r20_busy", int'(busy), 0);
    chk("r20_wr_bank", int'(wr_bank), 0);
    pulse_done("idle_done_ignored", 0, 1'b0);
    chk("r21_layer_cnt", int'(layer_cnt), 20);
    chk("r21_wr_bank", int'(wr_bank), 0);
    xfer(32, 0, 1, 1'b0);
    chk("sat_busy_run", int'(busy), 1);
    pulse_done("sat_drain_swap_cycles", 3, 1'b0);
    chk("sat_layer_cnt", int'(layer_cnt), 20);
    chk("sat_busy_idle", int'(busy), 0);
    chk("sat_wr_bank", int'(wr_bank), 1);

    // Asynchronous reset with two transfers in flight
    xfer(160, 0, 2, 1'b0);
    xfer(160, 0, 4, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ready", int'(acc_ready), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_wr_bank", int'(wr_bank), 0);
    chk("arst_layer_cnt", int'(layer_cnt), 0);
    chk("arst_rd_data", int'(rd_data), 0);
    chk("arst_rd_valid", int'(rd_valid), 0);
    repeat (2) tick;
    rst = 1'b1;
    #1;
    chk("arst_release_ready", int'(acc_ready), 1);
    clear_model;
    read_all("arst");
    chk("arst_final_wr_bank", int'(wr_bank), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
